// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port DataRAM between the CPU MEM stage and
// a host/loader port. The CPU has priority. A waiting host is admitted after
// at most STARVE_LIMIT CPU-owned cycles, and its bursts are capped at
// HOST_BURST transfers while the CPU is waiting.
module dmem_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 6,
    parameter int STARVE_LIMIT = 4,
    parameter int HOST_BURST   = 2
) (
    input  logic              clk,
    input  logic              reset,
    // CPU MEM stage
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    // host / loader port
    input  logic              host_valid,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    // DataRAM
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_spo
);

    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam int BW = (HOST_BURST > 1) ? $clog2(HOST_BURST) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);
    localparam logic [BW-1:0] BURST_MAX  = BW'(HOST_BURST - 1);

    typedef enum logic {S_CPU = 1'b0, S_HOST = 1'b1} state_t;

    // one RAM port request, as driven by whichever side owns the RAM
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              we;
    } ram_req_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

    logic     cpu_gnt;
    logic     host_xfer;
    ram_req_t ram_req;

    // owner register; reset always hands the RAM back to the CPU
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_CPU;
        end else begin
            state_q <= state_d;
        end
    end

    // ownership hand-over: the switch lands one cycle after the decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CPU: begin
                if (host_valid && (!cpu_req || starve_q == STARVE_MAX)) begin
                    state_d = S_HOST;
                end
            end
            S_HOST: begin
                // in S_HOST a valid host is always a transfer
                if (!host_valid || (cpu_req && burst_q == BURST_MAX)) begin
                    state_d = S_CPU;
                end
            end
            default: state_d = S_CPU;
        endcase
    end

    // grants and RAM mux, decoded from the registered owner only
    always_comb begin
        cpu_gnt    = (state_q == S_CPU);
        host_ready = (state_q == S_HOST);
        host_xfer  = host_ready & host_valid;
        cpu_stall  = cpu_req & ~cpu_gnt;
        if (cpu_gnt) begin
            ram_req.a  = cpu_addr;
            ram_req.d  = cpu_wdata;
            ram_req.we = cpu_req & cpu_we;
        end else begin
            ram_req.a  = host_addr;
            ram_req.d  = host_wdata;
            ram_req.we = host_valid & host_we;
        end
    end

    assign ram_a     = ram_req.a;
    assign ram_d     = ram_req.d;
    assign ram_we    = ram_req.we;
    assign cpu_rdata = ram_spo;

    // fairness counters: starvation while CPU owns, burst length while host owns
    always_comb begin
        starve_d = starve_q;
        burst_d  = burst_q;
        if (state_q == S_CPU) begin
            burst_d = '0;
            if (!host_valid || state_d == S_HOST) begin
                starve_d = '0;
            end else if (cpu_req && starve_q != STARVE_MAX) begin
                starve_d = starve_q + 1'b1;
            end
        end else begin
            starve_d = '0;
            if (state_d == S_CPU) begin
                burst_d = '0;
            end else if (host_xfer && cpu_req && burst_q != BURST_MAX) begin
                burst_d = burst_q + 1'b1;
            end
        end
    end

    // host read return: capture RAM data at the read transfer edge
    always_comb begin
        host_rvalid_d = host_xfer & ~host_we;
        host_rdata_d  = host_rvalid_d ? ram_spo : host_rdata_q;
    end

    // counter and read-return registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q      <= '0;
            burst_q       <= '0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            starve_q      <= starve_d;
            burst_q       <= burst_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of the DataRAM arbiter. u0 uses default
// parameters, u1 runs with STARVE_LIMIT=1 / HOST_BURST=1. Both share stimulus
// and each has its own behavioural single-port RAM.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, host_valid, host_we;
    logic [AW-1:0] cpu_addr, host_addr;
    logic [DW-1:0] cpu_wdata, host_wdata;

    logic [DW-1:0] cpu_rdata0, host_rdata0, ram_d0, ram_spo0;
    logic [DW-1:0] cpu_rdata1, host_rdata1, ram_d1, ram_spo1;
    logic [AW-1:0] ram_a0, ram_a1;
    logic          cpu_stall0, host_ready0, host_rvalid0, ram_we0;
    logic          cpu_stall1, host_ready1, host_rvalid1, ram_we1;

    logic [DW-1:0] mem0 [64];
    logic [DW-1:0] mem1 [64];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(4), .HOST_BURST(2)) u0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata0), .cpu_stall(cpu_stall0),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready0), .host_rdata(host_rdata0),
        .host_rvalid(host_rvalid0),
        .ram_a(ram_a0), .ram_d(ram_d0), .ram_we(ram_we0), .ram_spo(ram_spo0)
    );

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(1), .HOST_BURST(1)) u1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata1), .cpu_stall(cpu_stall1),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready1), .host_rdata(host_rdata1),
        .host_rvalid(host_rvalid1),
        .ram_a(ram_a1), .ram_d(ram_d1), .ram_we(ram_we1), .ram_spo(ram_spo1)
    );

    // behavioural DataRAMs: write at clock edge, combinational read
    always @(posedge clk) begin
        if (ram_we0) mem0[ram_a0] <= ram_d0;
        if (ram_we1) mem1[ram_a1] <= ram_d1;
    end
    assign ram_spo0 = mem0[ram_a0];
    assign ram_spo1 = mem1[ram_a1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic e;

        // reset with both requesters active
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        host_valid = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        #2;
        chk("rst_host_ready", 64'(host_ready0), 64'd0);
        chk("rst_cpu_stall", 64'(cpu_stall0), 64'd0);
        chk("rst_rvalid", 64'(host_rvalid0), 64'd0);
        chk("rst_rdata", 64'(host_rdata0), 64'd0);
        tick(); tick();
        reset = 1'b0; cpu_req = 1'b0; host_valid = 1'b0;
        tick();

        // T1: CPU write then read, zero added latency
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd7; cpu_wdata = 32'h11111111;
        tick();
        cpu_addr = 6'd5; cpu_wdata = 32'hDEADBEEF;
        #1;
        chk("t1_wr_stall", 64'(cpu_stall0), 64'd0);
        chk("t1_ram_we", 64'(ram_we0), 64'd1);
        chk("t1_ram_a", 64'(ram_a0), 64'd5);
        tick();
        cpu_we = 1'b0;
        #1;
        chk("t1_rdata", 64'(cpu_rdata0), 64'hDEADBEEF);
        chk("t1_rd_stall", 64'(cpu_stall0), 64'd0);
        tick();
        cpu_req = 1'b0;

        // T2: host write then read with idle CPU
        host_valid = 1'b1; host_we = 1'b1; host_addr = 6'd3; host_wdata = 32'h12345678;
        #1;
        chk("t2_ready_wait", 64'(host_ready0), 64'd0);
        tick();
        chk("t2_ready", 64'(host_ready0), 64'd1);
        chk("t2_ram_a", 64'(ram_a0), 64'd3);
        chk("t2_ram_we", 64'(ram_we0), 64'd1);
        tick();
        host_we = 1'b0;
        #1;
        chk("t2_rvalid_early", 64'(host_rvalid0), 64'd0);
        tick();
        host_valid = 1'b0;
        #1;
        chk("t2_rvalid", 64'(host_rvalid0), 64'd1);
        chk("t2_rdata", 64'(host_rdata0), 64'h12345678);
        tick();
        chk("t2_rvalid_drop", 64'(host_rvalid0), 64'd0);
        chk("t2_ready_drop", 64'(host_ready0), 64'd0);

        // T3: both saturated -> 4 CPU cycles, 2 host cycles, repeating
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd5;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 6'd3;
        for (int i = 0; i < 12; i++) begin
            #1;
            e = ((i % 6) >= 4);
            chk($sformatf("t3_ready[%0d]", i), 64'(host_ready0), 64'(e));
            chk($sformatf("t3_stall[%0d]", i), 64'(cpu_stall0), 64'(e));
            tick();
        end

        // T4: simultaneous rise from idle; host waits STARVE_LIMIT cycles
        cpu_req = 1'b0; host_valid = 1'b0;
        tick(); tick();
        cpu_req = 1'b1; host_valid = 1'b1;
        #1;
        cnt = 0;
        while (host_ready0 !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("t4_wait_cycles", 64'(cnt), 64'd4);
        chk("t4_stall", 64'(cpu_stall0), 64'd1);

        // T5: async reset mid host burst (read done, write pending)
        tick();
        #1;
        chk("t5_rvalid_pre", 64'(host_rvalid0), 64'd1);
        host_we = 1'b1; host_addr = 6'd7; host_wdata = 32'hCAFEF00D;
        #1;
        chk("t5_we_pending", 64'(ram_we0), 64'd1);
        reset = 1'b1;
        #1;
        chk("t5_ready_rst", 64'(host_ready0), 64'd0);
        chk("t5_rvalid_rst", 64'(host_rvalid0), 64'd0);
        chk("t5_stall_rst", 64'(cpu_stall0), 64'd0);
        chk("t5_we_rst", 64'(ram_we0), 64'd0);
        tick();
        reset = 1'b0; host_valid = 1'b0; host_we = 1'b0;
        #1;
        chk("t5_stall_post", 64'(cpu_stall0), 64'd0);
        chk("t5_rdata_post", 64'(host_rdata0), 64'd0);
        cpu_addr = 6'd7;
        #1;
        chk("t5_no_write", 64'(cpu_rdata0), 64'h11111111);
        cpu_addr = 6'd3;
        #1;
        chk("t5_ram_kept", 64'(cpu_rdata0), 64'h12345678);
        tick();

        // T6: limits of 1 -> strict alternation, both writing same addresses
        cpu_we = 1'b1; host_we = 1'b1; host_valid = 1'b1; cpu_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cpu_addr = AW'(16 + i); host_addr = AW'(16 + i);
            cpu_wdata = 32'h100 + i; host_wdata = 32'h200 + i;
            #1;
            chk($sformatf("t6_ready[%0d]", i), 64'(host_ready1), 64'(i % 2));
            chk($sformatf("t6_stall[%0d]", i), 64'(cpu_stall1), 64'(i % 2));
            tick();
        end
        host_valid = 1'b0; cpu_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cpu_addr = AW'(16 + i);
            #1;
            chk($sformatf("t6_mem[%0d]", 16 + i), 64'(cpu_rdata1),
                64'((i % 2 == 0) ? (32'h100 + i) : (32'h200 + i)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
